vga_timing_generator: RTL and testbench

Generates 640x480@60 Hz VGA raster timing from `VGA_clk` and drives the pixel coordinates and `display_on` consumed by the image renderer. It also delays the sync and blank signals so they stay aligned with the renderer's RGB output, registers that RGB onto the DAC pins, and emits per-frame and animation ticks for game logic.

---
 rtl/vga_timing_generator_pkg.sv | 29 ++
 rtl/vga_timing_generator_delay_line.sv | 46 ++++
 rtl/vga_timing_generator.sv | 146 ++++++++++++++
 tb/tb_vga_timing_generator.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_generator_pkg.sv
// vga_pkg: shared VGA definitions for the timing generator and the renderer.
//   - 640x480@60 Hz porch/sync constants and the derived line/frame totals
//   - 24-bit {R,G,B} colour type
//   - transparent colour key understood by the renderer
package vga_pkg;

  // Sum of the four segments of one axis (visible, front, sync, back).
  function automatic int axis_total(input int vis, input int front,
                                    input int sync, input int back);
    return vis + front + sync + back;
  endfunction

  localparam int H_VISIBLE_640 = 640;
  localparam int H_FRONT_640   = 16;
  localparam int H_SYNC_640    = 96;
  localparam int H_BACK_640    = 48;
  localparam int V_VISIBLE_480 = 480;
  localparam int V_FRONT_480   = 10;
  localparam int V_SYNC_480    = 2;
  localparam int V_BACK_480    = 33;

  localparam int H_TOTAL_640 = axis_total(H_VISIBLE_640, H_FRONT_640, H_SYNC_640, H_BACK_640);
  localparam int V_TOTAL_480 = axis_total(V_VISIBLE_480, V_FRONT_480, V_SYNC_480, V_BACK_480);

  typedef logic [23:0] color_t;

  localparam color_t TRANSPARENT_KEY = 24'hFF0096;

endpackage

// File: rtl/vga_timing_generator_delay_line.sv
// delay_line: fixed-depth shift register with a per-bit reset value.
//   VGA_clk   : clock
//   rst       : asynchronous, active-high reset (all stages load RESET_VAL)
//   din       : value entering the first stage
//   dout      : last stage (din delayed by DEPTH cycles)
//   dout_prev : the stage feeding dout (din itself when DEPTH is 1)
module delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             VGA_clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dout_prev
);

  logic [WIDTH-1:0] stage_reg [DEPTH];

  always_ff @(posedge VGA_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_reg[i] <= RESET_VAL;
      end
    end else begin
      stage_reg[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign dout = stage_reg[DEPTH-1];

  // The tap one stage before the output lets a consumer register data so it
  // lands on the same edge as dout.
  generate
    if (DEPTH == 1) begin : g_tap_input
      assign dout_prev = din;
    end else begin : g_tap_stage
      assign dout_prev = stage_reg[DEPTH-2];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_generator.sv
// vga_timing_generator: VGA raster timing, sync/blank alignment and DAC
// registering.
//   VGA_clk, rst        : pixel clock, asynchronous active-high reset
//   RGB                 : renderer pixel, valid PIPE_DELAY cycles after X/Y
//   X, Y, display_on    : current raster position and visible-area flag
//   frame_tick          : one-cycle pulse at the start of vertical blank
//   ani_tick            : one-cycle pulse every ANI_DIV frames
//   VGA_HS, VGA_VS      : active-low syncs, delayed to match the RGB path
//   VGA_BLANK_N         : low outside the visible area, delayed likewise
//   VGA_SYNC_N          : tied low
//   VGA_R, VGA_G, VGA_B : registered colour, forced to 0 while blanked
module vga_timing_generator
  import vga_pkg::*;
#(
  parameter int H_VISIBLE  = H_VISIBLE_640,
  parameter int H_FRONT    = H_FRONT_640,
  parameter int H_SYNC     = H_SYNC_640,
  parameter int H_BACK     = H_BACK_640,
  parameter int V_VISIBLE  = V_VISIBLE_480,
  parameter int V_FRONT    = V_FRONT_480,
  parameter int V_SYNC     = V_SYNC_480,
  parameter int V_BACK     = V_BACK_480,
  parameter int PIPE_DELAY = 2,
  parameter int ANI_DIV    = 6
) (
  input  logic        VGA_clk,
  input  logic        rst,
  input  logic [23:0] RGB,
  output logic [15:0] X,
  output logic [15:0] Y,
  output logic        display_on,
  output logic        frame_tick,
  output logic        ani_tick,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B
);

  localparam int H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_VIS    = 16'(H_VISIBLE);
  localparam logic [15:0] V_VIS    = 16'(V_VISIBLE);
  localparam logic [15:0] HS_START = 16'(H_VISIBLE + H_FRONT);
  localparam logic [15:0] HS_END   = 16'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [15:0] VS_START = 16'(V_VISIBLE + V_FRONT);
  localparam logic [15:0] VS_END   = 16'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam int              ANI_W    = (ANI_DIV > 1) ? $clog2(ANI_DIV) : 1;
  localparam logic [ANI_W-1:0] ANI_LAST = ANI_W'(ANI_DIV - 1);

  logic [15:0]      h_reg;
  logic [15:0]      v_reg;
  logic             hs_reg;
  logic             vs_reg;
  logic [ANI_W-1:0] frame_cnt_reg;
  color_t           rgb_out_reg;

  logic h_wrap;
  logic v_wrap;
  logic frame_cond;
  logic ani_wrap;

  assign h_wrap     = (h_reg == H_LAST);
  assign v_wrap     = (v_reg == V_LAST);
  assign frame_cond = (h_reg == 16'd0) && (v_reg == V_VIS);
  assign ani_wrap   = (frame_cnt_reg == ANI_LAST);

  // Every output here is derived from the pre-increment counters, so X/Y and
  // the raw syncs all describe the same raster position on the same edge.
  always_ff @(posedge VGA_clk or posedge rst) begin
    if (rst) begin
      h_reg         <= '0;
      v_reg         <= '0;
      X             <= '0;
      Y             <= '0;
      display_on    <= 1'b0;
      hs_reg        <= 1'b1;
      vs_reg        <= 1'b1;
      frame_tick    <= 1'b0;
      ani_tick      <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      h_reg <= h_wrap ? 16'd0 : h_reg + 16'd1;
      if (h_wrap) begin
        v_reg <= v_wrap ? 16'd0 : v_reg + 16'd1;
      end
      X          <= h_reg;
      Y          <= v_reg;
      display_on <= (h_reg < H_VIS) && (v_reg < V_VIS);
      hs_reg     <= !((h_reg >= HS_START) && (h_reg < HS_END));
      vs_reg     <= !((v_reg >= VS_START) && (v_reg < VS_END));
      frame_tick <= frame_cond;
      ani_tick   <= frame_cond && ani_wrap;
      if (frame_cond) begin
        frame_cnt_reg <= ani_wrap ? '0 : frame_cnt_reg + 1'b1;
      end
    end
  end

  // The registered sync/blank flags already sit one stage behind the counters,
  // alongside X/Y; the renderer adds PIPE_DELAY and the DAC register one more.
  logic [2:0] dl_out;
  logic [2:0] dl_prev;

  delay_line #(
    .WIDTH     (3),
    .DEPTH     (PIPE_DELAY + 1),
    .RESET_VAL (3'b110)
  ) u_delay_line (
    .VGA_clk   (VGA_clk),
    .rst       (rst),
    .din       ({hs_reg, vs_reg, display_on}),
    .dout      (dl_out),
    .dout_prev (dl_prev)
  );

  // Only the blank bit of the early tap gates the colour register.
  logic unused_taps;
  assign unused_taps = &{1'b0, dl_prev[2:1]};

  // Gated by the stage that becomes VGA_BLANK_N on this same edge, so colour
  // and blank switch together.
  always_ff @(posedge VGA_clk or posedge rst) begin
    if (rst) begin
      rgb_out_reg <= '0;
    end else begin
      rgb_out_reg <= dl_prev[0] ? RGB : '0;
    end
  end

  assign VGA_HS      = dl_out[2];
  assign VGA_VS      = dl_out[1];
  assign VGA_BLANK_N = dl_out[0];
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = rgb_out_reg[23:16];
  assign VGA_G       = rgb_out_reg[15:8];
  assign VGA_B       = rgb_out_reg[7:0];

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator.
//   dut   : default 640x480 geometry, PIPE_DELAY=2 -- reset, line wrap, sync
//           and pixel alignment, mid-frame reset.
//   dut_s : shrunken 10x7 raster (same PIPE_DELAY, ANI_DIV=3) so that vertical
//           sync and the frame/animation ticks can be seen over many frames.
module tb_vga_timing_generator;

  logic VGA_clk = 1'b0;
  always #5 VGA_clk = ~VGA_clk;

  logic        rst;
  logic        rst_s;
  logic [23:0] rgb_in;
  logic [23:0] rgb_s;

  logic [15:0] x, y;
  logic        display_on, frame_tick, ani_tick;
  logic        hs, vs, blank_n, sync_n;
  logic [7:0]  r, g, b;

  logic [15:0] s_x, s_y;
  logic        s_display_on, s_frame_tick, s_ani_tick;
  logic        s_hs, s_vs, s_blank_n, s_sync_n;
  logic [7:0]  s_r, s_g, s_b;

  vga_timing_generator #(.PIPE_DELAY(2), .ANI_DIV(6)) dut (
    .VGA_clk(VGA_clk), .rst(rst), .RGB(rgb_in),
    .X(x), .Y(y), .display_on(display_on),
    .frame_tick(frame_tick), .ani_tick(ani_tick),
    .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_N(blank_n), .VGA_SYNC_N(sync_n),
    .VGA_R(r), .VGA_G(g), .VGA_B(b)
  );

  vga_timing_generator #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(3),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .PIPE_DELAY(2), .ANI_DIV(3)
  ) dut_s (
    .VGA_clk(VGA_clk), .rst(rst_s), .RGB(rgb_s),
    .X(s_x), .Y(s_y), .display_on(s_display_on),
    .frame_tick(s_frame_tick), .ani_tick(s_ani_tick),
    .VGA_HS(s_hs), .VGA_VS(s_vs), .VGA_BLANK_N(s_blank_n), .VGA_SYNC_N(s_sync_n),
    .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // X/Y seen on the last four edges of dut (index 3 = three edges ago).
  logic [15:0] hx [4];
  logic [15:0] hy [4];
  bit          hv [4];

  task automatic clear_hist();
    for (int i = 0; i < 4; i++) begin
      hx[i] = '0; hy[i] = '0; hv[i] = 1'b0;
    end
    rgb_in = '0;
  endtask

  // Advance one cycle, sample just after the edge, then play the renderer:
  // present the colour of the X/Y that appeared two edges ago.
  task automatic tick();
    @(posedge VGA_clk);
    #1;
    for (int i = 3; i > 0; i--) begin
      hx[i] = hx[i-1]; hy[i] = hy[i-1]; hv[i] = hv[i-1];
    end
    hx[0] = x; hy[0] = y; hv[0] = 1'b1;
    rgb_in = hv[2] ? {hx[2][7:0], hy[2][7:0], 8'h5A} : 24'h0;
  endtask

  // dut state tracking for sync pulse measurement
  bit prev_hs;
  bit hs_fell;
  int hs_low;
  int t656;

  task automatic big_cycle(input int n);
    int  idx, ex, ey;
    bit  eb, ehs, evs;
    idx = n - 1;
    ex  = idx % 800;
    ey  = (idx / 800) % 525;
    check_eq("x", 32'(x), 32'(ex));
    check_eq("y", 32'(y), 32'(ey));
    check_eq("display_on", 32'(display_on), 32'(ex < 640 && ey < 480));
    check_eq("frame_tick", 32'(frame_tick), 32'(ex == 0 && ey == 480));
    check_eq("ani_tick", 32'(ani_tick), 32'(0));
    eb  = hv[3] && (hx[3] < 640) && (hy[3] < 480);
    ehs = !(hv[3] && (hx[3] >= 656) && (hx[3] < 752));
    evs = !(hv[3] && (hy[3] >= 490) && (hy[3] < 492));
    check_eq("blank_n", 32'(blank_n), 32'(eb));
    check_eq("hs", 32'(hs), 32'(ehs));
    check_eq("vs", 32'(vs), 32'(evs));
    check_eq("vga_r", 32'(r), eb ? 32'(hx[3][7:0]) : 32'(0));
    check_eq("vga_g", 32'(g), eb ? 32'(hy[3][7:0]) : 32'(0));
    check_eq("vga_b", 32'(b), eb ? 32'h5A : 32'(0));
    if (ex == 656) t656 = n;
    if (prev_hs && !hs) begin
      check_eq("hs_fall_delay", 32'(n - t656), 32'(3));
      hs_fell = 1'b1;
      hs_low  = 0;
    end
    if (!hs) hs_low++;
    if (!prev_hs && hs && hs_fell) check_eq("hs_low_width", 32'(hs_low), 32'(96));
    prev_hs = hs;
    if (ex == 799) $display("line y=%0d done at cycle %0d", ey, n);
  endtask

  // dut_s tracking
  int  k_ft, ft_cnt, ani_cnt, t04, vs_low;
  bit  prev_vs, vs_fell;

  task automatic small_reset_track();
    k_ft = 0; ft_cnt = 0; ani_cnt = 0; t04 = 0; vs_low = 0;
    prev_vs = 1'b1; vs_fell = 1'b0;
  endtask

  task automatic small_cycle(input int m);
    int idx, sx, sy;
    bit eft, eani;
    idx = m - 1;
    sx  = idx % 10;
    sy  = (idx / 10) % 7;
    check_eq("s_x", 32'(s_x), 32'(sx));
    check_eq("s_y", 32'(s_y), 32'(sy));
    check_eq("s_display_on", 32'(s_display_on), 32'(sx < 4 && sy < 3));
    eft = (sx == 0) && (sy == 3);
    if (eft) k_ft++;
    eani = eft && (k_ft % 3 == 0);
    check_eq("s_frame_tick", 32'(s_frame_tick), 32'(eft));
    check_eq("s_ani_tick", 32'(s_ani_tick), 32'(eani));
    if (s_frame_tick) begin
      ft_cnt++;
      $display("frame_tick #%0d at (%0d,%0d) ani=%0b", ft_cnt, s_x, s_y, s_ani_tick);
    end
    if (s_ani_tick) ani_cnt++;
    if (sx == 0 && sy == 4) t04 = m;
    if (prev_vs && !s_vs) begin
      check_eq("s_vs_fall_delay", 32'(m - t04), 32'(3));
      vs_fell = 1'b1;
      vs_low  = 0;
    end
    if (!s_vs) vs_low++;
    if (!prev_vs && s_vs && vs_fell) check_eq("s_vs_low_width", 32'(vs_low), 32'(20));
    prev_vs = s_vs;
  endtask

  initial begin
    rst   = 1'b1;
    rst_s = 1'b1;
    rgb_s = 24'hABCDEF;
    clear_hist();
    prev_hs = 1'b1; hs_fell = 1'b0; hs_low = 0; t656 = 0;
    small_reset_track();

    // Reset held for five cycles
    repeat (5) @(posedge VGA_clk);
    #1;
    check_eq("rst_x", 32'(x), 32'(0));
    check_eq("rst_y", 32'(y), 32'(0));
    check_eq("rst_display_on", 32'(display_on), 32'(0));
    check_eq("rst_frame_tick", 32'(frame_tick), 32'(0));
    check_eq("rst_ani_tick", 32'(ani_tick), 32'(0));
    check_eq("rst_hs", 32'(hs), 32'(1));
    check_eq("rst_vs", 32'(vs), 32'(1));
    check_eq("rst_blank_n", 32'(blank_n), 32'(0));
    check_eq("rst_sync_n", 32'(sync_n), 32'(0));
    check_eq("rst_rgb", 32'({r, g, b}), 32'(0));
    check_eq("rst_s_xy", 32'({s_x, s_y}), 32'(0));
    check_eq("rst_s_flags", 32'({s_display_on, s_frame_tick, s_ani_tick}), 32'(0));
    check_eq("rst_s_sync", 32'({s_hs, s_vs, s_blank_n, s_sync_n}), 32'(4'b1100));
    check_eq("rst_s_rgb", 32'({s_r, s_g, s_b}), 32'(0));
    $display("reset state sampled");

    // Two full lines plus part of a third: line wrap, hsync, pixel alignment
    rst = 1'b0;
    for (int n = 1; n <= 1901; n++) begin
      tick();
      big_cycle(n);
    end

    // Mid-line reset at (300,2): must clear without waiting for an edge
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_x", 32'(x), 32'(0));
    check_eq("mid_rst_y", 32'(y), 32'(0));
    check_eq("mid_rst_display_on", 32'(display_on), 32'(0));
    check_eq("mid_rst_sync", 32'({hs, vs, blank_n}), 32'(3'b110));
    check_eq("mid_rst_rgb", 32'({r, g, b}), 32'(0));
    $display("mid-frame reset applied at line 2");
    clear_hist();
    prev_hs = 1'b1; hs_fell = 1'b0; hs_low = 0; t656 = 0;
    @(posedge VGA_clk);
    #3;
    rst = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      big_cycle(n);
    end
    $display("restart after mid-frame reset checked");

    // Small raster: vsync window and frame/animation ticks over seven frames
    rst_s = 1'b0;
    for (int m = 1; m <= 515; m++) begin
      tick();
      small_cycle(m);
    end
    check_eq("s_frame_tick_count", 32'(ft_cnt), 32'(7));
    check_eq("s_ani_tick_count", 32'(ani_cnt), 32'(2));

    // Reset mid-frame (4,2): frame counter must restart from zero
    #2;
    rst_s = 1'b1;
    #1;
    check_eq("s_mid_rst_xy", 32'({s_x, s_y}), 32'(0));
    check_eq("s_mid_rst_flags", 32'({s_display_on, s_frame_tick, s_ani_tick}), 32'(0));
    check_eq("s_mid_rst_sync", 32'({s_hs, s_vs, s_blank_n}), 32'(3'b110));
    check_eq("s_mid_rst_rgb", 32'({s_r, s_g, s_b}), 32'(0));
    $display("small raster reset mid-frame");
    small_reset_track();
    @(posedge VGA_clk);
    #3;
    rst_s = 1'b0;
    for (int m = 1; m <= 250; m++) begin
      tick();
      small_cycle(m);
    end
    check_eq("s_frame_tick_count_after_rst", 32'(ft_cnt), 32'(4));
    check_eq("s_ani_tick_count_after_rst", 32'(ani_cnt), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
